cla_seq_adder: RTL and testbench

- Parametrised, multi-cycle add/subtract unit. Processes a WIDTH-bit operand pair one CHUNK-bit carry-lookahead slice per clock, LSB slice first, and passes the carry between slices through a register.
- Successor to the fixed 4-bit lookahead adder. Adds generic width, subtract mode, status flags and a valid/ready handshake on both sides.
- Sits between the register-file read stage and the writeback mux of the datapath. Area-cheap alternative to a full-width single-cycle adder.

---
 rtl/cla_seq_pkg.sv | 22 ++
 rtl/cla_seq_adder_chunk.sv | 48 ++++
 rtl/cla_seq_adder.sv | 148 ++++++++++++++
 tb/tb_cla_seq_adder.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_seq_pkg.sv
// cla_seq_pkg: shared types and sizing helpers for the sequential lookahead adder.
//   state_t       - controller states (IDLE, BUSY, DONE)
//   num_chunks()  - number of CHUNK-bit slices in a WIDTH-bit operand
//   cnt_width()   - width of the slice counter for a given slice count
package cla_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int unsigned num_chunks(input int unsigned width, input int unsigned chunk);
    return width / chunk;
  endfunction

  // A single slice still needs a one-bit counter so the register is never zero-width.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cla_seq_adder_chunk.sv
// cla_chunk: purely combinational CHUNK-bit carry-lookahead slice.
// Ports:
//   a, b   - slice operands (CHUNK bits)
//   c_in   - carry into bit 0
//   s      - slice sum (CHUNK bits)
//   c_out  - carry out of the top bit
//   c_msb  - carry into the top bit (used for signed overflow)
module cla_chunk #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             c_in,
  output logic [CHUNK-1:0] s,
  output logic             c_out,
  output logic             c_msb
);

  logic [CHUNK-1:0] p;
  logic [CHUNK-1:0] g;
  logic [CHUNK:0]   carry;

  assign p = a ^ b;
  assign g = a & b;

  // Every carry is a flat sum of products over g/p and c_in, no ripple chain:
  // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i]..p[0]c_in
  always_comb begin
    logic prod;
    carry    = '0;
    prod     = 1'b0;
    carry[0] = c_in;
    for (int i = 0; i < int'(CHUNK); i++) begin
      carry[i+1] = g[i];
      prod       = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        carry[i+1] = carry[i+1] | (prod & g[j]);
        prod       = prod & p[j];
      end
      carry[i+1] = carry[i+1] | (prod & c_in);
    end
  end

  assign s     = p ^ carry[CHUNK-1:0];
  assign c_out = carry[CHUNK];
  assign c_msb = carry[CHUNK-1];

endmodule

// File: rtl/cla_seq_adder.sv
// cla_seq_adder: multi-cycle add/subtract unit resolving one CHUNK-bit lookahead slice
// per clock, LSB slice first, with the inter-slice carry held in a register.
// Optional feature macro: CLA_SEQ_ADDER_SAT_EN (signed saturation on overflow).
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   in_valid / in_ready - operand handshake; a, b, cin, sub sampled on accept
//   a, b                - WIDTH-bit operands
//   cin                 - carry-in for add (ignored when sub = 1)
//   sub                 - 1: a - b, 0: a + b + cin
//   out_valid/out_ready - result handshake; sum/flags held while out_valid
//   sum                 - result (shows partial slices while busy)
//   cout                - carry out of MSB (no-borrow in subtract mode)
//   ovf                 - signed overflow
//   zero                - sum == 0
module cla_seq_adder
  import cla_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned N  = num_chunks(WIDTH, CHUNK);
  localparam int unsigned IW = cnt_width(N);
  localparam logic [IW-1:0] LastIdx = IW'(N - 1);

  state_t           state_q;
  logic [IW-1:0]    idx_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;

  int unsigned      base;
  logic [CHUNK-1:0] sl_a;
  logic [CHUNK-1:0] sl_b;
  logic [CHUNK-1:0] sl_s;
  logic             sl_cout;
  logic             sl_cmsb;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] sum_ins;
  logic [WIDTH-1:0] sum_fin;
  logic             ovf_w;

  // Operand slice select for the current index.
  always_comb begin
    base = 32'(idx_q) * CHUNK;
    sl_a = CHUNK'(a_q >> base);
    sl_b = CHUNK'(b_q >> base);
  end

  cla_chunk #(
    .CHUNK(CHUNK)
  ) u_chunk (
    .a    (sl_a),
    .b    (sl_b),
    .c_in (carry_q),
    .s    (sl_s),
    .c_out(sl_cout),
    .c_msb(sl_cmsb)
  );

  // Merge the slice result into the running sum; on the final slice this is the result.
  always_comb begin
    mask    = WIDTH'({CHUNK{1'b1}}) << base;
    sum_ins = (sum_q & ~mask) | (WIDTH'(sl_s) << base);
    ovf_w   = sl_cout ^ sl_cmsb;
    sum_fin = sum_ins;
`ifdef CLA_SEQ_ADDER_SAT_EN
    // Overflow direction follows the sign of A: positive A can only overflow upward.
    if (ovf_w) begin
      sum_fin = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            // Subtract as A + ~B + 1.
            b_q     <= sub ? ~b : b;
            carry_q <= sub ? 1'b1 : cin;
            sum_q   <= '0;
            idx_q   <= '0;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          carry_q <= sl_cout;
          if (idx_q == LastIdx) begin
            sum_q   <= sum_fin;
            cout_q  <= sl_cout;
            ovf_q   <= ovf_w;
            zero_q  <= (sum_fin == '0);
            state_q <= DONE;
          end else begin
            sum_q <= sum_ins;
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_cla_seq_adder.sv
// tb_cla_seq_adder: scoreboard bench for cla_seq_adder (WIDTH=32, CHUNK=4).
// Expected results come from signed/unsigned integer arithmetic on the operands.
module tb_cla_seq_adder;

  localparam int W = 32;
  localparam int N = 8;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         zero;

  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;
  exp_t exp_q[$];
  int   acc_q[$];
  logic force_rdy  = 1'b1;
  logic rdy_val    = 1'b1;
  logic prev_ov    = 1'b0;

  cla_seq_adder #(
    .WIDTH(32),
    .CHUNK(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .ovf      (ovf),
    .zero     (zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    out_ready = force_rdy ? rdy_val : 1'(($urandom % 4) != 0);
  end

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                 input logic icin, input logic isub);
    exp_t   e;
    longint sa;
    longint sb;
    longint r;
    logic [W:0] full;
    sa = longint'($signed(ia));
    sb = longint'($signed(ib));
    if (isub) begin
      r      = sa - sb;
      e.sum  = ia - ib;
      e.cout = (ia >= ib);
    end else begin
      r      = sa + sb + longint'(icin);
      full   = {1'b0, ia} + {1'b0, ib} + {{W{1'b0}}, icin};
      e.sum  = full[W-1:0];
      e.cout = full[W];
    end
    e.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
`ifdef CLA_SEQ_ADDER_SAT_EN
    if (r > 64'sd2147483647) e.sum = 32'h7FFF_FFFF;
    else if (r < -64'sd2147483648) e.sum = 32'h8000_0000;
`endif
    e.zero = (e.sum == '0);
    return e;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accept edge.
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic icin, input logic isub);
    int n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      compared++;
      mismatched++;
      $display("FAIL accept_wait: in_ready=%b expected 1 within 200 cycles", in_ready);
      return;
    end
    a        = ia;
    b        = ib;
    cin      = icin;
    sub      = isub;
    in_valid = 1'b1;
    exp_q.push_back(model(ia, ib, icin, isub));
    @(posedge clk);
    #1;
    acc_q.push_back(cyc);
    in_valid = 1'b0;
    // Scramble inputs: only the accept edge may matter.
    a   = $urandom;
    b   = $urandom;
    cin = 1'($urandom);
    sub = 1'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: compares the head of the scoreboard on every cycle out_valid is high,
  // so held results are re-checked during backpressure.
  always @(negedge clk) begin
    exp_t e;
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL spurious_out_valid: sum=%h with nothing expected", sum);
      end else begin
        e = exp_q[0];
        if (!prev_ov && acc_q.size() != 0) chk("latency", 32'(cyc - acc_q[0]), 32'(N));
        chk("sum", sum, e.sum);
        chk("cout", 32'(cout), 32'(e.cout));
        chk("ovf", 32'(ovf), 32'(e.ovf));
        chk("zero", 32'(zero), 32'(e.zero));
        chk("in_ready_done", 32'(in_ready), 32'd0);
        if (out_ready) begin
          void'(exp_q.pop_front());
          if (acc_q.size() != 0) void'(acc_q.pop_front());
        end
      end
    end
    prev_ov = out_valid;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst      = 1'b1;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    cin      = 1'b0;
    sub      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", sum, 32'd0);
    chk("rst_flags", {29'd0, cout, ovf, zero}, 32'd0);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", 32'(in_ready), 32'd1);

    // Directed cases.
    issue(32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0);
    issue(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
    issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    issue(32'd5, 32'd7, 1'b0, 1'b1);
    issue(32'd7, 32'd5, 1'b0, 1'b1);
    issue(32'd7, 32'd5, 1'b1, 1'b1);
    issue(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
    drain();

    // Backpressure: hold the result for 5 cycles while offering a new operation.
    rdy_val = 1'b0;
    @(posedge clk);
    #1;
    issue(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b1;
    a        = 32'hDEAD_BEEF;
    b        = 32'h0BAD_F00D;
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_held_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    rdy_val  = 1'b1;
    drain();
    chk("bp_back_to_idle", 32'(in_ready), 32'd1);

    // Reset on the third BUSY cycle abandons the operation.
    issue(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    exp_q.delete();
    acc_q.delete();
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_sum", sum, 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("postrst_in_ready", 32'(in_ready), 32'd1);
    chk("postrst_out_valid", 32'(out_valid), 32'd0);
    issue(32'd3, 32'd4, 1'b0, 1'b0);
    drain();

    // Randomised operations with random consumer backpressure.
    force_rdy = 1'b0;
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ra = $urandom;
      rb = $urandom;
      if (i % 8 == 3) rb = ra;
      if (i % 8 == 5) ra = 32'h7FFF_FFFF;
      if (i % 8 == 6) ra = 32'h8000_0000;
      issue(ra, rb, 1'($urandom), 1'($urandom));
    end
    force_rdy = 1'b1;
    rdy_val   = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
